// File: rtl/elvds_tx_sched.sv
// Round-robin scheduler and UART-style framer for two byte streams sharing one
// ELVDS_TBUF output; the pair is driven only while a guarded frame is on the wire.
module elvds_tx_sched #(
    parameter int DIV   = 4,
    parameter int GUARD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       tx_i,
    output logic       tx_oen,
    output logic       busy,
    output logic       owner
);
    localparam int CW   = $clog2(DIV);
    localparam int IMAX = (GUARD > 8) ? GUARD : 8;
    localparam int IW   = $clog2(IMAX);

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [IW-1:0] GUARD_LAST = IW'(GUARD - 1);
    localparam logic [IW-1:0] DATA_LAST  = IW'(7);

    typedef enum logic [2:0] {IDLE, LEAD, START, DATA, STOP, WAIT, TRAIL} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [7:0]    data_q;
    logic          last_q, owner_q, rr, hold;
    logic [1:0]    ready, valid;
    logic          winner, bit_end, take, sel;
    logic          tx_i_d, tx_oen_d;

    assign valid   = {s1_valid, s0_valid};
    assign bit_end = (cnt == CNT_LAST);
    assign winner  = (&valid) ? rr : s1_valid;

    // hold blocks any grant in the first cycle after reset releases.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        ready = 2'b00;
        if (!rst && !hold) begin
            case (state)
                IDLE:    if (|valid) ready[winner] = 1'b1;
                STOP:    if (bit_end && !last_q) ready[owner_q] = 1'b1;
                WAIT:    ready[owner_q] = 1'b1;
                default: ready = 2'b00;
            endcase
        end
    end

    assign take     = |(ready & valid);
    assign sel      = ready[1];
    assign s0_ready = ready[0];
    assign s1_ready = ready[1];

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (take) state_n = LEAD;
            LEAD:    if (bit_end && idx == GUARD_LAST) state_n = START;
            START:   if (bit_end) state_n = DATA;
            DATA:    if (bit_end && idx == DATA_LAST) state_n = STOP;
            STOP:    if (bit_end) state_n = last_q ? TRAIL : (take ? START : WAIT);
            WAIT:    if (take) state_n = START;
            TRAIL:   if (bit_end && idx == GUARD_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        cnt_n = cnt + CW'(1);
        idx_n = idx;
        if (state_n != state || state == IDLE || state == WAIT) begin
            cnt_n = '0;
            idx_n = '0;
        end else if (bit_end) begin
            cnt_n = '0;
            idx_n = idx + IW'(1);
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with it.
    always_comb begin
        tx_oen_d = (state_n == IDLE);
        case (state_n)
            START:   tx_i_d = 1'b0;
            DATA:    tx_i_d = data_q[idx_n[2:0]];
            default: tx_i_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values.
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            tx_i   <= 1'b1;
            tx_oen <= 1'b1;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            tx_i   <= tx_i_d;
            tx_oen <= tx_oen_d;
        end
    end

    always_ff @(posedge clk) begin
        hold <= rst;
        if (rst) begin
            owner_q <= 1'b0;
            rr      <= 1'b0;
            last_q  <= 1'b0;
        end else if (take) begin
            last_q  <= sel ? s1_last : s0_last;
            owner_q <= sel;
            if (state == IDLE) rr <= ~sel;
        end
    end

    // NOTE: the payload register has no reset; it is read only after a capture loads it.
    always_ff @(posedge clk) begin
        if (take) data_q <= sel ? s1_data : s0_data;
    end

    assign busy  = (state != IDLE);
    assign owner = owner_q;
endmodule

// File: tb/tb_elvds_tx_sched.sv
// Directed bench for elvds_tx_sched with DIV=4, GUARD=2: framing, arbitration,
// underrun and reset behaviour, checked with immediate assertions.
module tb_elvds_tx_sched;
    localparam int DIV   = 4;
    localparam int GUARD = 2;

    logic       clk;
    logic       rst;
    logic       s0_valid, s0_last, s0_ready;
    logic [7:0] s0_data;
    logic       s1_valid, s1_last, s1_ready;
    logic [7:0] s1_data;
    logic       tx_i, tx_oen, busy, owner;

    int n_cmp = 0;
    int n_err = 0;

    elvds_tx_sched #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .s1_ready (s1_ready),
        .tx_i     (tx_i),
        .tx_oen   (tx_oen),
        .busy     (busy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time budget exceeded");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle tx_i for a frame, optionally starting at the lead guard.
    task automatic gen(input int nb, input logic [15:0] bytes, input bit lead,
                       output logic [255:0] w, output int n);
        logic [7:0] b;
        w = '0;
        n = 0;
        if (lead) for (int i = 0; i < GUARD*DIV; i++) begin w[n] = 1'b1; n++; end
        for (int j = 0; j < nb; j++) begin
            b = bytes[8*j +: 8];
            for (int c = 0; c < DIV; c++) begin w[n] = 1'b0; n++; end
            for (int k = 0; k < 8; k++)
                for (int c = 0; c < DIV; c++) begin w[n] = b[k]; n++; end
            for (int c = 0; c < DIV; c++) begin w[n] = 1'b1; n++; end
        end
        for (int i = 0; i < GUARD*DIV; i++) begin w[n] = 1'b1; n++; end
    endtask

    // Record tx_i while tx_oen is low; returns on the first cycle with tx_oen high.
    task automatic watch(input int max_cyc, input bit drop, output int len,
                         output logic [255:0] wave, output int r0, output int r1);
        bit done = 0;
        bit pend;
        len = 0; wave = '0; r0 = 0; r1 = 0;
        for (int k = 0; k < max_cyc; k++) begin
            #1;
            if (tx_oen !== 1'b0) begin done = 1; break; end
            wave[len] = tx_i;
            len++;
            r0 += int'(s0_ready);
            r1 += int'(s1_ready);
            pend = drop && (s0_ready || s1_ready);
            next_cycle();
            if (pend) begin s0_valid = 1'b0; s1_valid = 1'b0; end
        end
        if (!done) check("watch_bound_oen", tx_oen, 1'b1);
    endtask

    logic [255:0] w, ew;
    int len, elen, r0, r1, steps, bad, rdy;
    bit got;

    initial begin
        // Reset state, with a request already pending
        rst = 1'b1;
        s0_valid = 1'b1; s0_data = 8'hA5; s0_last = 1'b1;
        s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
        next_cycle();
        next_cycle();
        check("rst_tx_oen", tx_oen, 1'b1);
        check("rst_tx_i", tx_i, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_owner", owner, 1'b0);
        check("rst_ready", {s1_ready, s0_ready}, 2'b00);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {s1_ready, s0_ready}, 2'b00);

        // Single byte 0xA5 from s0
        next_cycle();
        check("single_grant", {s1_ready, s0_ready}, 2'b01);
        check("single_grant_oen", tx_oen, 1'b1);
        next_cycle();
        s0_valid = 1'b0;
        #1;
        check("single_busy", busy, 1'b1);
        check("single_owner", owner, 1'b0);
        watch(100, 0, len, w, r0, r1);
        gen(1, 16'h00A5, 1, ew, elen);
        check("single_len", len, 56);
        check("single_wave", w, ew);
        check("single_ready_in_frame", r0, 0);
        check("single_end_busy", busy, 1'b0);

        // Simultaneous requests at reset release
        rst = 1'b1;
        s0_valid = 1'b1; s0_data = 8'h12; s0_last = 1'b1;
        s1_valid = 1'b1; s1_data = 8'h34; s1_last = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        check("sim_hold_ready", {s1_ready, s0_ready}, 2'b00);
        next_cycle();
        check("sim_first_grant", {s1_ready, s0_ready}, 2'b01);
        next_cycle();
        s0_valid = 1'b0;
        watch(100, 0, len, w, r0, r1);
        gen(1, 16'h0012, 1, ew, elen);
        check("sim_s0_len", len, 56);
        check("sim_s0_wave", w, ew);
        check("sim_s1_ready_blocked", r1, 0);
        check("sim_second_grant", {s1_ready, s0_ready}, 2'b10);
        next_cycle();
        s1_valid = 1'b0;
        #1;
        check("sim_back_to_back_oen", tx_oen, 1'b0);
        check("sim_s1_owner", owner, 1'b1);
        watch(100, 0, len, w, r0, r1);
        gen(1, 16'h0034, 1, ew, elen);
        check("sim_s1_len", len, 56);
        check("sim_s1_wave", w, ew);

        // Fairness: both requesters offer continuously
        s0_valid = 1'b1; s0_data = 8'h5A; s0_last = 1'b1;
        s1_valid = 1'b1; s1_data = 8'hC3; s1_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            #1;
            for (int g = 0; g < 10 && !got; g++) begin
                if (s0_ready || s1_ready) got = 1;
                else next_cycle();
            end
            check($sformatf("fair_grant_%0d", k), {s1_ready, s0_ready}, (k % 2) ? 2'b10 : 2'b01);
            next_cycle();
            if (k == 3) begin s0_valid = 1'b0; s1_valid = 1'b0; end
            check($sformatf("fair_owner_%0d", k), owner, (k % 2) ? 1'b1 : 1'b0);
            watch(100, 0, len, w, r0, r1);
            gen(1, (k % 2) ? 16'h00C3 : 16'h005A, 1, ew, elen);
            check($sformatf("fair_wave_%0d", k), w, ew);
            check($sformatf("fair_len_%0d", k), len, 56);
        end

        // Multi-byte frame from s1: 0x00 then 0xFF
        s1_valid = 1'b1; s1_data = 8'h00; s1_last = 1'b0;
        #1;
        check("multi_grant", {s1_ready, s0_ready}, 2'b10);
        next_cycle();
        s1_data = 8'hFF; s1_last = 1'b1;
        watch(150, 1, len, w, r0, r1);
        gen(2, 16'hFF00, 1, ew, elen);
        check("multi_len", len, 96);
        check("multi_wave", w, ew);
        check("multi_stop_ready", r1, 1);
        check("multi_s0_ready", r0, 0);

        // Underrun on s0
        s0_valid = 1'b1; s0_data = 8'h81; s0_last = 1'b0;
        #1;
        check("under_grant", {s1_ready, s0_ready}, 2'b01);
        next_cycle();
        s0_valid = 1'b0;
        #1;
        steps = 0;
        while (s0_ready !== 1'b1 && steps < 100) begin
            next_cycle();
            steps++;
        end
        check("under_stop_ready_cycle", steps, 47);
        check("under_stop_tx_i", tx_i, 1'b1);
        bad = 0;
        rdy = 0;
        for (int k = 0; k < 21; k++) begin
            next_cycle();
            if (tx_oen !== 1'b0 || tx_i !== 1'b1) bad++;
            rdy += int'(s0_ready);
        end
        check("under_wait_line", bad, 0);
        check("under_wait_ready", rdy, 21);
        s0_valid = 1'b1; s0_data = 8'h7E; s0_last = 1'b1;
        #1;
        check("under_accept", {s1_ready, s0_ready}, 2'b01);
        next_cycle();
        s0_valid = 1'b0;
        #1;
        check("under_start_bit", {tx_oen, tx_i}, 2'b00);
        watch(100, 0, len, w, r0, r1);
        gen(1, 16'h007E, 0, ew, elen);
        check("under_tail_len", len, 48);
        check("under_tail_wave", w, ew);

        // Reset in the middle of a DATA bit
        s0_valid = 1'b1; s0_data = 8'hF0; s0_last = 1'b1;
        #1;
        check("mid_grant", {s1_ready, s0_ready}, 2'b01);
        next_cycle();
        s0_valid = 1'b0;
        repeat (18) next_cycle();
        check("mid_busy_before", {busy, tx_oen}, 2'b10);
        rst = 1'b1;
        s0_valid = 1'b1; s0_data = 8'h44; s0_last = 1'b1;
        s1_valid = 1'b1; s1_data = 8'h55; s1_last = 1'b1;
        #1;
        check("mid_rst_ready", {s1_ready, s0_ready}, 2'b00);
        next_cycle();
        check("mid_after_oen", tx_oen, 1'b1);
        check("mid_after_busy", busy, 1'b0);
        check("mid_after_owner", owner, 1'b0);
        rst = 1'b0;
        #1;
        check("mid_hold_ready", {s1_ready, s0_ready}, 2'b00);
        next_cycle();
        check("mid_regrant", {s1_ready, s0_ready}, 2'b01);
        next_cycle();
        s0_valid = 1'b0; s1_valid = 1'b0;
        #1;
        check("mid_new_owner", owner, 1'b0);
        watch(100, 0, len, w, r0, r1);
        gen(1, 16'h0044, 1, ew, elen);
        check("mid_new_len", len, 56);
        check("mid_new_wave", w, ew);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
